reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- In-order retirement buffer for the SSOOO core. Allocates ROB tags (ROBEN) to decoded instructions and captures out-of-order results from the common data bus (CDB).
- Retires one instruction per cycle to the register file's WP1 commit port.
- Raises ROB_FLUSH_Flag when a mispredicted instruction retires.
- Sources the ROBEN that decode places on Decoded_WP1_ROBEN, and the WP1_* / ROB_FLUSH_Flag signals the register file consumes.

Parameters:
- ROB_SIZE_bits, 4: log2 of entry count.
- ROB_SIZE, 1<<ROB_SIZE_bits: number of entries (16).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- alloc_valid  in  1  decode requests an entry.
- alloc_Wen  in  1  instruction writes a destination register.
- alloc_DRindex  in  5  destination register index.
- alloc_ready  out  1  entry available this cycle.
- alloc_ROBEN  out  ROB_SIZE_bits+1  tag granted (tail slot + 1).
- cdb_valid  in  1  result broadcast.
- cdb_ROBEN  in  ROB_SIZE_bits+1  tag of the result.
- cdb_data  in  32  result value.
- cdb_mispredict  in  1  producing branch/jump was mispredicted.
- rd1_ROBEN, rd2_ROBEN  in  ROB_SIZE_bits+1  operand tag lookups.
- rd1_ready, rd2_ready  out  1  looked-up result is available.
- rd1_data, rd2_data  out  32  looked-up result.
- WP1_Wen  out  1  commit write enable.
- WP1_ROBEN  out  ROB_SIZE_bits+1  committing tag.
- WP1_DRindex  out  5  committing destination register.
- WP1_Data  out  32  committing value.
- ROB_FLUSH_Flag  out  1  one-cycle flush pulse.

Behaviour:
- **Tags**
  - Tag = slot+1, range 1..ROB_SIZE. Tag 0 means "no producer" and is never issued.
- **State**
  - head, tail: ROB_SIZE_bits wide, wrap modulo ROB_SIZE.
  - count: ROB_SIZE_bits+1 wide.
  - Per entry: busy, ready, Wen, DRindex, data, mispredict.
- **Reset (rst=0, asynchronous)**
  - head=tail=count=0, all busy/ready cleared.
  - WP1_Wen=0, WP1_ROBEN=0, WP1_DRindex=0, WP1_Data=0, ROB_FLUSH_Flag=0.
- **Allocation**
  - alloc_ready = (count != ROB_SIZE) && !ROB_FLUSH_Flag, combinational.
  - alloc_ROBEN = tail+1, combinational, valid whenever alloc_ready=1.
  - Accept on alloc_valid && alloc_ready: entry[tail] gets busy=1, ready=0, mispredict=0, Wen, DRindex; tail increments.
- **Writeback**
  - On cdb_valid with cdb_ROBEN != 0 and entry busy: set ready=1, store data and mispredict.
  - CDB is ignored for non-busy entries, tag 0, or while ROB_FLUSH_Flag=1.
- **Lookup (combinational)**
  - tag 0 -> ready=0, data=0.
  - CDB hit on the same tag this cycle -> ready=1, data=cdb_data (bypass).
  - Otherwise ready = busy && ready, data = entry data.
- **Commit**
  - When entry[head] has busy && ready, the next edge registers:
    - WP1_Wen = entry Wen, WP1_ROBEN = head+1, WP1_DRindex, WP1_Data.
    - Entry is freed and head increments.
  - A result written by CDB in cycle N commits no earlier than the edge ending cycle N+1, because ready is registered.
  - Non-commit cycles: WP1_Wen=0, WP1_ROBEN=0; WP1_DRindex and WP1_Data hold their last values.
- **Flush**
  - If the committing entry has mispredict=1:
    - Its commit outputs are registered normally.
    - ROB_FLUSH_Flag=1 on the same edge, for exactly one cycle.
    - All entries are cleared and head=tail=count=0 on that edge; any same-cycle allocation is discarded.
  - While ROB_FLUSH_Flag=1: alloc_ready=0 and CDB is ignored. This matches the register file clearing tags that cycle.
- **Simultaneous events**
  - Allocate + commit in the same cycle: count unchanged.
  - Full + commit: alloc_ready remains 0 that cycle, since it is derived from registered count.
  - Wrap: tail 15 -> 0, and tag 1 is reissued only after it has retired.

Decomposition:
- Shared package `rob_pkg`:
  - ROB_SIZE_bits, ROB_SIZE, ROBEN width.
  - Tag-to-slot and slot-to-tag helpers.
  - Entry record typedef (busy, ready, Wen, DRindex, data, mispredict).
- One sub-module, `rob_entry_store`, is natural: the entry array with allocate/writeback/free/clear ports and two combinational lookup ports.
- Pointer, count, commit and flush logic stay in `reorder_buffer`.

Test Plan:
1. Release reset, allocate 3 entries (DR 5, 6, 7, Wen=1) -> alloc_ROBEN 1, 2, 3; WP1_Wen stays 0 with no CDB activity.
2. CDB tag 2 = 0x22, then tag 1 = 0x11 -> commits tag 1 (DR 5, 0x11) then tag 2 (DR 6, 0x22) on consecutive cycles.
3. Allocate 16 with none ready -> alloc_ready=0 at count 16; complete tag 1 -> it commits, next allocation receives tag 1 (wrap).
4. Five entries, CDB tag 2 with mispredict=1 -> tag 1 and tag 2 commit, and ROB_FLUSH_Flag=1 with WP1_ROBEN=2. In the flag cycle alloc_ready=0. Next cycle alloc_ROBEN=1, tags 3..5 never commit.
5. rd1_ROBEN=4 while CDB broadcasts tag 4 = 0xABCD -> same cycle rd1_ready=1, rd1_data=0xABCD; rd2_ROBEN=0 -> rd2_ready=0.
6. Drive rst=0 mid-operation with entries pending, between clock edges -> all outputs 0 immediately; after release, alloc_ROBEN=1.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared types and tag/slot helpers for the reorder buffer.
// A tag is the slot index plus one, so tag 0 can mean "no producer".
package rob_pkg;

  localparam int ROB_SIZE_bits = 4;
  localparam int ROB_SIZE      = 1 << ROB_SIZE_bits;
  localparam int ROBEN_W       = ROB_SIZE_bits + 1;

  typedef struct packed {
    logic        busy;
    logic        ready;
    logic        wen;
    logic [4:0]  dr;
    logic [31:0] data;
    logic        mispredict;
  } rob_entry_t;

  function automatic logic [ROB_SIZE_bits-1:0] tag_to_slot(input logic [ROBEN_W-1:0] tag);
    logic [ROBEN_W-1:0] t;
    t = tag - ROBEN_W'(1);
    return t[ROB_SIZE_bits-1:0];
  endfunction

  function automatic logic [ROBEN_W-1:0] slot_to_tag(input logic [ROB_SIZE_bits-1:0] slot);
    return {1'b0, slot} + ROBEN_W'(1);
  endfunction

  function automatic logic tag_valid(input logic [ROBEN_W-1:0] tag);
    return (tag != '0) && (tag <= ROBEN_W'(ROB_SIZE));
  endfunction

endpackage

// File: rtl/rob_entry_store.sv
// Entry array of the reorder buffer: allocate, CDB writeback, free, clear,
// plus two combinational operand lookups with same-cycle CDB bypass.
module rob_entry_store
  import rob_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clear,
  input  logic                     i_alloc_en,
  input  logic [ROB_SIZE_bits-1:0] i_alloc_slot,
  input  logic                     i_alloc_wen,
  input  logic [4:0]               i_alloc_dr,
  input  logic                     i_wb_en,
  input  logic [ROBEN_W-1:0]       i_wb_tag,
  input  logic [31:0]              i_wb_data,
  input  logic                     i_wb_mispredict,
  input  logic                     i_free_en,
  input  logic [ROB_SIZE_bits-1:0] i_head_slot,
  input  logic [ROBEN_W-1:0]       i_rd1_tag,
  input  logic [ROBEN_W-1:0]       i_rd2_tag,
  output logic                     o_rd1_ready,
  output logic [31:0]              o_rd1_data,
  output logic                     o_rd2_ready,
  output logic [31:0]              o_rd2_data,
  output logic                     o_head_busy,
  output logic                     o_head_ready,
  output logic                     o_head_wen,
  output logic [4:0]               o_head_dr,
  output logic [31:0]              o_head_data,
  output logic                     o_head_mispredict
);

  rob_entry_t               r_ent [ROB_SIZE];
  logic                     w_wb_hit;
  logic [ROB_SIZE_bits-1:0] w_wb_slot;
  logic [ROBEN_W-1:0]       w_rd_tag   [2];
  logic                     w_rd_ready [2];
  logic [31:0]              w_rd_data  [2];

  assign w_wb_slot = tag_to_slot(i_wb_tag);
  assign w_wb_hit  = i_wb_en && tag_valid(i_wb_tag) && r_ent[w_wb_slot].busy;

  // Free beats writeback on the same slot; alloc never collides with either
  // because an allocated slot is not busy and head==tail only when empty/full.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < ROB_SIZE; i++) r_ent[i] <= '0;
    end else if (i_clear) begin
      for (int i = 0; i < ROB_SIZE; i++) r_ent[i] <= '0;
    end else begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        if (i_alloc_en && (i_alloc_slot == ROB_SIZE_bits'(i))) begin
          r_ent[i].busy       <= 1'b1;
          r_ent[i].ready      <= 1'b0;
          r_ent[i].mispredict <= 1'b0;
          r_ent[i].wen        <= i_alloc_wen;
          r_ent[i].dr         <= i_alloc_dr;
        end else if (i_free_en && (i_head_slot == ROB_SIZE_bits'(i))) begin
          r_ent[i].busy  <= 1'b0;
          r_ent[i].ready <= 1'b0;
        end else if (w_wb_hit && (w_wb_slot == ROB_SIZE_bits'(i))) begin
          r_ent[i].ready      <= 1'b1;
          r_ent[i].data       <= i_wb_data;
          r_ent[i].mispredict <= i_wb_mispredict;
        end
      end
    end
  end

  assign w_rd_tag[0] = i_rd1_tag;
  assign w_rd_tag[1] = i_rd2_tag;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rd_ready[p] = 1'b0;
      w_rd_data[p]  = '0;
      if (tag_valid(w_rd_tag[p])) begin
        if (i_wb_en && (i_wb_tag == w_rd_tag[p])) begin
          w_rd_ready[p] = 1'b1;
          w_rd_data[p]  = i_wb_data;
        end else begin
          w_rd_ready[p] = r_ent[tag_to_slot(w_rd_tag[p])].busy && r_ent[tag_to_slot(w_rd_tag[p])].ready;
          w_rd_data[p]  = r_ent[tag_to_slot(w_rd_tag[p])].data;
        end
      end
    end
  end

  assign o_rd1_ready       = w_rd_ready[0];
  assign o_rd1_data        = w_rd_data[0];
  assign o_rd2_ready       = w_rd_ready[1];
  assign o_rd2_data        = w_rd_data[1];
  assign o_head_busy       = r_ent[i_head_slot].busy;
  assign o_head_ready      = r_ent[i_head_slot].ready;
  assign o_head_wen        = r_ent[i_head_slot].wen;
  assign o_head_dr         = r_ent[i_head_slot].dr;
  assign o_head_data       = r_ent[i_head_slot].data;
  assign o_head_mispredict = r_ent[i_head_slot].mispredict;

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates tags, captures CDB results and
// retires one entry per cycle to WP1, flushing when a mispredict retires.
module reorder_buffer
  import rob_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_valid,
  input  logic                 alloc_Wen,
  input  logic [4:0]           alloc_DRindex,
  output logic                 alloc_ready,
  output logic [ROBEN_W-1:0]   alloc_ROBEN,
  input  logic                 cdb_valid,
  input  logic [ROBEN_W-1:0]   cdb_ROBEN,
  input  logic [31:0]          cdb_data,
  input  logic                 cdb_mispredict,
  input  logic [ROBEN_W-1:0]   rd1_ROBEN,
  input  logic [ROBEN_W-1:0]   rd2_ROBEN,
  output logic                 rd1_ready,
  output logic                 rd2_ready,
  output logic [31:0]          rd1_data,
  output logic [31:0]          rd2_data,
  output logic                 WP1_Wen,
  output logic [ROBEN_W-1:0]   WP1_ROBEN,
  output logic [4:0]           WP1_DRindex,
  output logic [31:0]          WP1_Data,
  output logic                 ROB_FLUSH_Flag
);

  logic [ROB_SIZE_bits-1:0] r_head;
  logic [ROB_SIZE_bits-1:0] r_tail;
  logic [ROB_SIZE_bits:0]   r_count;
  logic                     w_alloc;
  logic                     w_commit;
  logic                     w_flush;
  logic                     w_wb_en;
  logic                     w_head_busy;
  logic                     w_head_ready;
  logic                     w_head_wen;
  logic [4:0]               w_head_dr;
  logic [31:0]              w_head_data;
  logic                     w_head_mispredict;

  // Handshake: an entry is taken on any cycle with alloc_valid && alloc_ready;
  // alloc_ROBEN is only meaningful while alloc_ready is high.
  assign alloc_ready = (r_count != ROBEN_W'(ROB_SIZE)) && !ROB_FLUSH_Flag;
  assign alloc_ROBEN = slot_to_tag(r_tail);
  assign w_alloc     = alloc_valid && alloc_ready;
  assign w_wb_en     = cdb_valid && !ROB_FLUSH_Flag;
  assign w_commit    = w_head_busy && w_head_ready;
  assign w_flush     = w_commit && w_head_mispredict;

  rob_entry_store u_store (
    .i_clk            (clk),
    .i_rst_n          (rst),
    .i_clear          (w_flush),
    .i_alloc_en       (w_alloc),
    .i_alloc_slot     (r_tail),
    .i_alloc_wen      (alloc_Wen),
    .i_alloc_dr       (alloc_DRindex),
    .i_wb_en          (w_wb_en),
    .i_wb_tag         (cdb_ROBEN),
    .i_wb_data        (cdb_data),
    .i_wb_mispredict  (cdb_mispredict),
    .i_free_en        (w_commit),
    .i_head_slot      (r_head),
    .i_rd1_tag        (rd1_ROBEN),
    .i_rd2_tag        (rd2_ROBEN),
    .o_rd1_ready      (rd1_ready),
    .o_rd1_data       (rd1_data),
    .o_rd2_ready      (rd2_ready),
    .o_rd2_data       (rd2_data),
    .o_head_busy      (w_head_busy),
    .o_head_ready     (w_head_ready),
    .o_head_wen       (w_head_wen),
    .o_head_dr        (w_head_dr),
    .o_head_data      (w_head_data),
    .o_head_mispredict(w_head_mispredict)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_commit) r_head <= r_head + 1'b1;
      if (w_alloc)  r_tail <= r_tail + 1'b1;
      r_count <= r_count + {{ROB_SIZE_bits{1'b0}}, w_alloc} - {{ROB_SIZE_bits{1'b0}}, w_commit};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      WP1_Wen        <= 1'b0;
      WP1_ROBEN      <= '0;
      WP1_DRindex    <= '0;
      WP1_Data       <= '0;
      ROB_FLUSH_Flag <= 1'b0;
    end else begin
      WP1_Wen        <= w_commit && w_head_wen;
      WP1_ROBEN      <= w_commit ? slot_to_tag(r_head) : '0;
      ROB_FLUSH_Flag <= w_flush;
      if (w_commit) begin
        WP1_DRindex <= w_head_dr;
        WP1_Data    <= w_head_data;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized and directed bench for reorder_buffer against an in-order
// queue model of the buffer contents.
module tb_reorder_buffer;
  import rob_pkg::*;

  logic        clk;
  logic        rst;
  logic        alloc_valid;
  logic        alloc_Wen;
  logic [4:0]  alloc_DRindex;
  logic        alloc_ready;
  logic [4:0]  alloc_ROBEN;
  logic        cdb_valid;
  logic [4:0]  cdb_ROBEN;
  logic [31:0] cdb_data;
  logic        cdb_mispredict;
  logic [4:0]  rd1_ROBEN;
  logic [4:0]  rd2_ROBEN;
  logic        rd1_ready;
  logic        rd2_ready;
  logic [31:0] rd1_data;
  logic [31:0] rd2_data;
  logic        WP1_Wen;
  logic [4:0]  WP1_ROBEN;
  logic [4:0]  WP1_DRindex;
  logic [31:0] WP1_Data;
  logic        ROB_FLUSH_Flag;

  reorder_buffer dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_Wen(alloc_Wen), .alloc_DRindex(alloc_DRindex),
    .alloc_ready(alloc_ready), .alloc_ROBEN(alloc_ROBEN),
    .cdb_valid(cdb_valid), .cdb_ROBEN(cdb_ROBEN), .cdb_data(cdb_data),
    .cdb_mispredict(cdb_mispredict),
    .rd1_ROBEN(rd1_ROBEN), .rd2_ROBEN(rd2_ROBEN),
    .rd1_ready(rd1_ready), .rd2_ready(rd2_ready),
    .rd1_data(rd1_data), .rd2_data(rd2_data),
    .WP1_Wen(WP1_Wen), .WP1_ROBEN(WP1_ROBEN), .WP1_DRindex(WP1_DRindex),
    .WP1_Data(WP1_Data), .ROB_FLUSH_Flag(ROB_FLUSH_Flag)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: program-order list of live instructions
  typedef struct {
    logic [4:0]  tag;
    logic        wen;
    logic [4:0]  dr;
    logic        rdy;
    logic [31:0] data;
    logic        mp;
  } m_ent_t;

  m_ent_t      m_q[$];
  logic [42:0] exp_q[$];  // expected commits {wen, tag, dr, data}
  logic [4:0]  m_next_tag;
  logic        m_flag;
  logic        m_commit;
  logic [4:0]  m_dr;
  logic [31:0] m_data;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_next_tag = 5'd1;
    m_flag     = 1'b0;
    m_commit   = 1'b0;
    m_dr       = '0;
    m_data     = '0;
  endtask

  function automatic logic [32:0] m_lookup(input logic [4:0] tag);
    if (tag == 5'd0) return '0;
    if (cdb_valid && !m_flag && cdb_ROBEN == tag) return {1'b1, cdb_data};
    foreach (m_q[i]) if (m_q[i].tag == tag && m_q[i].rdy) return {1'b1, m_q[i].data};
    return '0;
  endfunction

  task automatic check_comb();
    logic        can_alloc;
    logic [32:0] e;
    can_alloc = (m_q.size() < ROB_SIZE) && !m_flag;
    chk("alloc_ready", 32'(alloc_ready), 32'(can_alloc));
    if (can_alloc) chk("alloc_ROBEN", 32'(alloc_ROBEN), 32'(m_next_tag));
    e = m_lookup(rd1_ROBEN);
    chk("rd1_ready", 32'(rd1_ready), 32'(e[32]));
    if (e[32] || rd1_ROBEN == 5'd0) chk("rd1_data", rd1_data, e[31:0]);
    e = m_lookup(rd2_ROBEN);
    chk("rd2_ready", 32'(rd2_ready), 32'(e[32]));
    if (e[32] || rd2_ROBEN == 5'd0) chk("rd2_data", rd2_data, e[31:0]);
  endtask

  // Advance the model across one clock edge using the currently driven inputs
  task automatic model_edge();
    logic   accept;
    logic   flush;
    m_ent_t n;
    accept   = alloc_valid && (m_q.size() < ROB_SIZE) && !m_flag;
    flush    = 1'b0;
    m_commit = 1'b0;
    if (m_q.size() > 0 && m_q[0].rdy) begin
      m_commit = 1'b1;
      flush    = m_q[0].mp;
      exp_q.push_back({m_q[0].wen, m_q[0].tag, m_q[0].dr, m_q[0].data});
      void'(m_q.pop_front());
    end
    if (cdb_valid && !m_flag && cdb_ROBEN != 5'd0) begin
      foreach (m_q[i]) if (m_q[i].tag == cdb_ROBEN) begin
        m_q[i].rdy  = 1'b1;
        m_q[i].data = cdb_data;
        m_q[i].mp   = cdb_mispredict;
      end
    end
    if (accept && !flush) begin
      n.tag = m_next_tag; n.wen = alloc_Wen; n.dr = alloc_DRindex;
      n.rdy = 1'b0; n.data = '0; n.mp = 1'b0;
      m_q.push_back(n);
      m_next_tag = (m_next_tag == 5'(ROB_SIZE)) ? 5'd1 : m_next_tag + 5'd1;
    end
    if (flush) begin
      m_q.delete();
      m_next_tag = 5'd1;
    end
    m_flag = flush;
  endtask

  task automatic check_seq();
    logic [42:0] r;
    if (m_commit) begin
      r = exp_q.pop_front();
      chk("WP1_Wen", 32'(WP1_Wen), 32'(r[42]));
      chk("WP1_ROBEN", 32'(WP1_ROBEN), 32'(r[41:37]));
      chk("WP1_DRindex", 32'(WP1_DRindex), 32'(r[36:32]));
      chk("WP1_Data", WP1_Data, r[31:0]);
      m_dr   = r[36:32];
      m_data = r[31:0];
    end else begin
      chk("WP1_Wen_idle", 32'(WP1_Wen), 32'd0);
      chk("WP1_ROBEN_idle", 32'(WP1_ROBEN), 32'd0);
      chk("WP1_DRindex_hold", 32'(WP1_DRindex), 32'(m_dr));
      chk("WP1_Data_hold", WP1_Data, m_data);
    end
    chk("ROB_FLUSH_Flag", 32'(ROB_FLUSH_Flag), 32'(m_flag));
  endtask

  // Driver tasks: called at posedge+1, outputs checked at posedge+2
  task automatic drive(input logic av, input logic aw, input logic [4:0] adr,
                       input logic cv, input logic [4:0] ct, input logic [31:0] cd,
                       input logic cm, input logic [4:0] r1, input logic [4:0] r2);
    alloc_valid = av; alloc_Wen = aw; alloc_DRindex = adr;
    cdb_valid = cv; cdb_ROBEN = ct; cdb_data = cd; cdb_mispredict = cm;
    rd1_ROBEN = r1; rd2_ROBEN = r2;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
  endtask

  task automatic settle_check();
    #1;
    check_comb();
  endtask

  task automatic finish_cycle();
    model_edge();
    @(posedge clk);
    #1;
    check_seq();
  endtask

  task automatic cycle();
    settle_check();
    finish_cycle();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    chk("rst_WP1_Wen", 32'(WP1_Wen), 32'd0);
    chk("rst_WP1_ROBEN", 32'(WP1_ROBEN), 32'd0);
    chk("rst_WP1_DRindex", 32'(WP1_DRindex), 32'd0);
    chk("rst_WP1_Data", WP1_Data, 32'd0);
    chk("rst_flush", 32'(ROB_FLUSH_Flag), 32'd0);
    model_reset();
    idle();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_alloc_ROBEN", 32'(alloc_ROBEN), 32'd1);
    chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b0;
    idle();
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Three allocations, no results yet
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 5'(5 + i), 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
      cycle();
    end
    idle(); cycle();

    // Out-of-order results retire in order
    drive(1'b0, 1'b0, 5'd0, 1'b1, 5'd2, 32'h22, 1'b0, 5'd2, 5'd1); cycle();
    drive(1'b0, 1'b0, 5'd0, 1'b1, 5'd1, 32'h11, 1'b0, 5'd1, 5'd2); cycle();
    idle(); cycle();
    chk("t2_first_commit_dr", 32'(WP1_DRindex), 32'd5);
    idle(); cycle();
    chk("t2_second_commit_data", WP1_Data, 32'h22);

    // Fill to 16, then retire tag 1 and reuse it
    @(posedge clk); #1;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'($urandom_range(1)), 5'(i), 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
      cycle();
    end
    drive(1'b1, 1'b1, 5'd20, 1'b1, 5'd1, 32'h1111, 1'b0, 5'd1, 5'd16);
    settle_check();
    chk("t3_full_not_ready", 32'(alloc_ready), 32'd0);
    finish_cycle();
    drive(1'b1, 1'b1, 5'd21, 1'b0, 5'd0, 32'd0, 1'b0, 5'd1, 5'd0); cycle();
    drive(1'b1, 1'b1, 5'd22, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    settle_check();
    chk("t3_wrap_tag", 32'(alloc_ROBEN), 32'd1);
    finish_cycle();
    idle(); cycle();

    // Mispredict flush
    @(posedge clk); #1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 5'(10 + i), 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
      cycle();
    end
    drive(1'b0, 1'b0, 5'd0, 1'b1, 5'd2, 32'hB2, 1'b1, 5'd0, 5'd0); cycle();
    drive(1'b0, 1'b0, 5'd0, 1'b1, 5'd1, 32'hB1, 1'b0, 5'd0, 5'd0); cycle();
    drive(1'b0, 1'b0, 5'd0, 1'b1, 5'd3, 32'hB3, 1'b0, 5'd0, 5'd0); cycle();
    idle(); cycle();
    chk("t4_flush_flag", 32'(ROB_FLUSH_Flag), 32'd1);
    chk("t4_flush_roben", 32'(WP1_ROBEN), 32'd2);
    drive(1'b1, 1'b1, 5'd9, 1'b1, 5'd4, 32'hB4, 1'b0, 5'd3, 5'd0);
    settle_check();
    chk("t4_flag_blocks_alloc", 32'(alloc_ready), 32'd0);
    finish_cycle();
    drive(1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    settle_check();
    chk("t4_after_flush_tag", 32'(alloc_ROBEN), 32'd1);
    finish_cycle();
    for (int i = 0; i < 4; i++) begin idle(); cycle(); end

    // Lookup bypass
    @(posedge clk); #1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 5'(i), 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
      cycle();
    end
    drive(1'b0, 1'b0, 5'd0, 1'b1, 5'd4, 32'hABCD, 1'b0, 5'd4, 5'd0);
    settle_check();
    chk("t5_bypass_ready", 32'(rd1_ready), 32'd1);
    chk("t5_bypass_data", rd1_data, 32'hABCD);
    chk("t5_tag0_ready", 32'(rd2_ready), 32'd0);
    finish_cycle();

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      logic [4:0] ct;
      if (m_q.size() > 0 && $urandom_range(3) != 0) ct = m_q[$urandom_range(m_q.size() - 1)].tag;
      else ct = 5'($urandom_range(ROB_SIZE));
      drive(1'($urandom_range(9) < 6), 1'($urandom_range(1)), 5'($urandom_range(31)),
            1'($urandom_range(1)), ct, $urandom, 1'($urandom_range(19) == 0),
            5'($urandom_range(ROB_SIZE)), 5'($urandom_range(ROB_SIZE)));
      cycle();
    end

    // Asynchronous reset with entries pending
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 5'(i), 1'b1, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
      cycle();
    end
    do_reset();
    idle(); cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
